// File: rtl/pr_uart_tx_if.sv
// Register-bus port bundle for the UART transmitter: word address, write strobe,
// write data and combinational read data.
interface pr_uart_tx_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, output WE, output Din, input Dout);
    modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/pr_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/CTRL/DIV registers, one frame at a
// time, divisor sampled at frame start, DONE-based level interrupt.
module pr_uart_tx #(
    parameter logic [15:0] DIV_RESET = 16'd16
) (
    input  logic         clk,
    input  logic         reset,
    pr_uart_tx_if.slave  bus,
    output logic         IRQ,
    output logic         TxD
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_r;
    logic [7:0]  shift_r;
    logic [7:0]  data_byte_r;
    logic [15:0] bit_div_r;
    logic [15:0] timer_r;
    logic [2:0]  bit_idx_r;
    logic        txd_r;
    logic        done_r;
    logic        ie_r;
    logic [15:0] div_r;

    logic        wr_data_s;
    logic        bit_end_s;
    logic        stop_done_s;
    logic        unused_s;

    // A zero divisor is treated as one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

    assign wr_data_s   = bus.WE && (bus.Addr == 2'd0);
    assign bit_end_s   = (timer_r == (bit_div_r - 16'd1));
    assign stop_done_s = (state_r == STOP) && bit_end_s;
    assign unused_s    = ^bus.Din[31:16];

    // Frame sequencer: bit timing, shifting and the registered serial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            shift_r     <= 8'd0;
            data_byte_r <= 8'd0;
            bit_div_r   <= 16'd1;
            timer_r     <= 16'd0;
            bit_idx_r   <= 3'd0;
            txd_r       <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (wr_data_s) begin
                        shift_r     <= bus.Din[7:0];
                        data_byte_r <= bus.Din[7:0];
                        bit_div_r   <= eff_div(div_r);
                        timer_r     <= 16'd0;
                        bit_idx_r   <= 3'd0;
                        txd_r       <= 1'b0;
                        state_r     <= START;
                    end else begin
                        txd_r <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        timer_r <= 16'd0;
                        txd_r   <= shift_r[0];
                        state_r <= DATA;
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        timer_r <= 16'd0;
                        if (bit_idx_r == 3'd7) begin
                            txd_r   <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            // The next bit is visible one cycle early as shift_r[1].
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        timer_r <= 16'd0;
                        txd_r   <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                default: begin
                    txd_r   <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Control registers; completion of STOP beats a simultaneous DONE clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r <= 1'b0;
            ie_r   <= 1'b0;
            div_r  <= DIV_RESET;
        end else begin
            if (stop_done_s) begin
                done_r <= 1'b1;
            end else if (bus.WE && (bus.Addr == 2'd1) && bus.Din[1]) begin
                done_r <= 1'b0;
            end
            if (bus.WE && (bus.Addr == 2'd2)) begin
                ie_r <= bus.Din[0];
            end
            if (bus.WE && (bus.Addr == 2'd3)) begin
                div_r <= bus.Din[15:0];
            end
        end
    end

    // Read mux depends on the address and register state only.
    always_comb begin
        bus.Dout = 32'd0;
        case (bus.Addr)
            2'd0:    bus.Dout = {24'd0, data_byte_r};
            2'd1:    bus.Dout = {30'd0, done_r, (state_r != IDLE)};
            2'd2:    bus.Dout = {31'd0, ie_r};
            2'd3:    bus.Dout = {16'd0, div_r};
            default: bus.Dout = 32'd0;
        endcase
    end

    assign IRQ = done_r & ie_r;
    assign TxD = txd_r;
endmodule

// File: tb/tb_pr_uart_tx.sv
// Directed bench for pr_uart_tx: expected serial bits are queued when a frame is
// launched and popped against TxD every cycle.
module tb_pr_uart_tx;
    logic clk;
    logic reset;
    logic irq;
    logic txd;
    int   checks;
    int   failures;
    bit   exp_q[$];

    pr_uart_tx_if bus_if();

    pr_uart_tx #(.DIV_RESET(16'd16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .IRQ   (irq),
        .TxD   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] b, input int d);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < d; k++) exp_q.push_back(bits[i]);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.Addr = a;
        bus_if.WE   = 1'b1;
        bus_if.Din  = d;
        @(negedge clk);
        bus_if.WE   = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus_if.Addr = a;
        #1;
        check(tag, bus_if.Dout, exp);
    endtask

    // n cycles: compare TxD to the scoreboard (idle high when empty), BUSY and IRQ;
    // optionally issue one write at iteration wat.
    task automatic run(input string tag, input int n, input logic busy_exp, input logic irq_exp,
                       input int wat, input logic [1:0] wa, input logic [31:0] wd);
        logic exp_bit;
        for (int i = 0; i < n; i++) begin
            bus_if.Addr = 2'd1;
            bus_if.WE   = 1'b0;
            #1;
            exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
            check({tag, "_txd"}, {31'd0, txd}, {31'd0, exp_bit});
            check({tag, "_busy"}, {31'd0, bus_if.Dout[0]}, {31'd0, busy_exp});
            check({tag, "_irq"}, {31'd0, irq}, {31'd0, irq_exp});
            if (i == wat) begin
                bus_if.Addr = wa;
                bus_if.Din  = wd;
                bus_if.WE   = 1'b1;
            end
            @(negedge clk);
            bus_if.WE = 1'b0;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus_if.Addr = 2'd0;
        bus_if.WE   = 1'b0;
        bus_if.Din  = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        chk_reg("rst_data", 2'd0, 32'd0);
        chk_reg("rst_status", 2'd1, 32'd0);
        chk_reg("rst_ctrl", 2'd2, 32'd0);
        chk_reg("rst_div", 2'd3, 32'd16);

        // DIV=4, 0xA5
        @(negedge clk);
        wr(2'd3, 32'd4);
        chk_reg("div4_rb", 2'd3, 32'd4);
        push_frame(8'hA5, 4);
        wr(2'd0, 32'hFFFF_FFA5);
        run("a5", 40, 1'b1, 1'b0, -1, 2'd0, 32'd0);
        chk_reg("a5_status", 2'd1, 32'd2);
        chk_reg("a5_data", 2'd0, 32'hA5);

        // IRQ with DIV=2
        wr(2'd1, 32'd2);
        chk_reg("clr_status", 2'd1, 32'd0);
        wr(2'd2, 32'd1);
        chk_reg("ctrl_rb", 2'd2, 32'd1);
        wr(2'd3, 32'd2);
        push_frame(8'h3C, 2);
        wr(2'd0, 32'h3C);
        run("irqf", 19, 1'b1, 1'b0, -1, 2'd0, 32'd0);
        // on the next edge STOP ends; a DATA write there is ignored
        run("irqe", 1, 1'b1, 1'b0, 0, 2'd0, 32'h55);
        check("irq_rise", {31'd0, irq}, 32'd1);
        chk_reg("irq_status", 2'd1, 32'd2);
        run("stopedge", 4, 1'b0, 1'b1, -1, 2'd0, 32'd0);
        chk_reg("stopedge_data", 2'd0, 32'h3C);
        wr(2'd1, 32'd2);
        check("irq_drop", {31'd0, irq}, 32'd0);
        wr(2'd2, 32'd0);

        // Mid-frame DATA write ignored
        wr(2'd3, 32'd4);
        push_frame(8'hFF, 4);
        wr(2'd0, 32'hFF);
        run("ff", 40, 1'b1, 1'b0, 10, 2'd0, 32'h55);
        chk_reg("ff_status", 2'd1, 32'd2);
        chk_reg("ff_data", 2'd0, 32'hFF);
        wr(2'd1, 32'd2);
        run("ff_after", 12, 1'b0, 1'b0, -1, 2'd0, 32'd0);
        chk_reg("ff_one_done", 2'd1, 32'd0);

        // DIV=0 behaves as 1
        wr(2'd3, 32'd0);
        chk_reg("div0_rb", 2'd3, 32'd0);
        push_frame(8'h01, 1);
        wr(2'd0, 32'h01);
        run("d0", 10, 1'b1, 1'b0, -1, 2'd0, 32'd0);
        chk_reg("d0_status", 2'd1, 32'd2);
        wr(2'd1, 32'd2);

        // DIV change mid-frame applies to the next frame only
        wr(2'd3, 32'd4);
        push_frame(8'h96, 4);
        wr(2'd0, 32'h96);
        run("d4", 40, 1'b1, 1'b0, 5, 2'd3, 32'd8);
        chk_reg("d4_status", 2'd1, 32'd2);
        chk_reg("d8_rb", 2'd3, 32'd8);
        push_frame(8'h69, 8);
        wr(2'd0, 32'h69);
        run("d8", 80, 1'b1, 1'b0, -1, 2'd0, 32'd0);
        chk_reg("d8_status", 2'd1, 32'd2);
        wr(2'd1, 32'd2);

        // Reset mid-frame, with a simultaneous DATA write
        wr(2'd3, 32'd4);
        push_frame(8'h5A, 4);
        wr(2'd0, 32'h5A);
        run("abort", 13, 1'b1, 1'b0, -1, 2'd0, 32'd0);
        exp_q.delete();
        bus_if.Addr = 2'd0;
        bus_if.Din  = 32'h77;
        bus_if.WE   = 1'b1;
        reset       = 1'b1;
        @(negedge clk);
        bus_if.WE   = 1'b0;
        reset       = 1'b0;
        check("abort_txd", {31'd0, txd}, 32'd1);
        check("abort_irq", {31'd0, irq}, 32'd0);
        chk_reg("abort_status", 2'd1, 32'd0);
        chk_reg("abort_div", 2'd3, 32'd16);
        chk_reg("abort_data", 2'd0, 32'd0);
        run("abort_idle", 8, 1'b0, 1'b0, -1, 2'd0, 32'd0);
        chk_reg("abort_nodone", 2'd1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
